// File: rtl/fib_chk_if.sv
// fib_chk_if: word-stream input and run-status output bundle for fib_seq_checker.
interface fib_chk_if #(
    parameter int DATA_W = 24,
    parameter int IDX_W  = 6,
    parameter int ERR_W  = 8
);
    logic              start;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              busy;
    logic              done;
    logic              pass;
    logic              mismatch;
    logic [DATA_W-1:0] exp_data;
    logic [ERR_W-1:0]  err_cnt;
    logic [IDX_W-1:0]  first_err_idx;
    logic [IDX_W-1:0]  word_cnt;
    modport master (
        output start, in_valid, in_data,
        input  busy, done, pass, mismatch, exp_data, err_cnt, first_err_idx, word_cnt
    );
    modport slave (
        input  start, in_valid, in_data,
        output busy, done, pass, mismatch, exp_data, err_cnt, first_err_idx, word_cnt
    );
endinterface

// File: rtl/fib_seq_checker.sv
// fib_seq_checker: checks each streamed word equals the sum of the two words received before it.
// Optional FIB_CHK_SEED_EN: words 0 and 1 must also equal 0 and 1.
module fib_seq_checker #(
    parameter int DATA_W    = 24,
    parameter int NUM_WORDS = 36,
    parameter int IDX_W     = 6,
    parameter int ERR_W     = 8
) (
    input logic      clk,
    input logic      reset,
    fib_chk_if.slave bus
);
    typedef enum logic [2:0] {IDLE, PRIME0, PRIME1, CHECK, DONE} state_t;
    state_t            r_state, w_next;
    logic [DATA_W-1:0] r_h1, r_h2, r_exp, w_exp;
    logic [ERR_W-1:0]  r_err, w_err;
    logic [IDX_W-1:0]  r_first, r_wcnt;
    logic              r_done, r_pass, r_mis;
    logic              w_run, w_acc, w_chk, w_bad, w_last;

    assign w_run  = r_state inside {PRIME0, PRIME1, CHECK};
    assign w_acc  = bus.in_valid && !bus.start && w_run;
    assign w_last = r_state == CHECK && r_wcnt == IDX_W'(NUM_WORDS - 1);
`ifdef FIB_CHK_SEED_EN
    assign w_chk  = w_acc;
    assign w_exp  = r_state == CHECK ? r_h1 + r_h2 : DATA_W'(r_state == PRIME1);
`else
    assign w_chk  = w_acc && r_state == CHECK;
    assign w_exp  = r_h1 + r_h2;
`endif
    assign w_bad  = w_chk && bus.in_data != w_exp;
    assign w_err  = (w_bad && !(&r_err)) ? r_err + 1'b1 : r_err;

    always_ff @(posedge clk) r_state <= reset ? IDLE : w_next;

    always_comb begin
        w_next = r_state;
        if (bus.start)
            w_next = PRIME0;
        else if (w_acc)
            w_next = r_state == PRIME0 ? PRIME1 : r_state == PRIME1 ? CHECK : w_last ? DONE : CHECK;
    end

    // History holds the received words, so one bad word poisons the next two checks too.
    always_ff @(posedge clk) begin
        if (reset || bus.start) begin
            r_h1    <= '0;
            r_h2    <= '0;
            r_exp   <= '0;
            r_err   <= '0;
            r_first <= '0;
            r_wcnt  <= '0;
            r_done  <= 1'b0;
            r_pass  <= 1'b0;
            r_mis   <= 1'b0;
        end else begin
            r_mis <= w_bad;
            if (w_chk)
                r_exp <= w_exp;
            if (w_acc) begin
                r_wcnt <= r_wcnt + 1'b1;
                r_h2   <= r_h1;
                r_h1   <= bus.in_data;
            end
            if (w_bad) begin
                r_err <= w_err;
                if (r_err == '0)
                    r_first <= r_wcnt;
            end
            if (w_acc && w_last) begin
                r_done <= 1'b1;
                r_pass <= w_err == '0;
            end
        end
    end

    assign bus.busy          = w_run;
    assign bus.done          = r_done;
    assign bus.pass          = r_pass;
    assign bus.mismatch      = r_mis;
    assign bus.exp_data      = r_exp;
    assign bus.err_cnt       = r_err;
    assign bus.first_err_idx = r_first;
    assign bus.word_cnt      = r_wcnt;
endmodule
